// File: rtl/expr_eval.sv
// -----------------------------------------------------------------------------
// expr_eval
//
// Evaluates single-digit arithmetic expressions delivered one ASCII character
// per accepted beat. Operands are '0'..'9', operators are '+' and '*', and '*'
// binds tighter than '+'. Each expression ends with the beat that carries
// in_last. One cycle after that beat the block presents a registered result
// for one cycle. Malformed expressions are flagged on err.
//
// Evaluation keeps three pieces of state:
//   sum      : total of all completed '+' terms
//   prod     : value of the product term currently being built
//   mul_pend : a '*' has been seen, so the next digit multiplies into prod
//
// Parameters:
//   W             width of result and accumulators; arithmetic wraps mod 2^W
//
// Ports:
//   clk           rising-edge clock
//   clr_n         asynchronous active-low reset
//   in_valid      in / in_last are meaningful; when low, all state holds
//   in            ASCII character
//   in_last       marks the final character of the expression
//   result        value of the last completed expression (held between pulses)
//   result_valid  one-cycle pulse when result/err/ovf update
//   err           last completed expression was malformed
//   ovf           arithmetic wrap happened in the last expression
//
// Configuration:
//   EXPR_EVAL_OVF_EN  when defined, ovf reports whether any product or sum in
//                     the expression exceeded 2^W-1 at full precision. ovf is
//                     forced to 0 on errored expressions. When undefined, ovf
//                     is tied to 0.
// -----------------------------------------------------------------------------
module expr_eval #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         in_valid,
  input  logic [7:0]   in,
  input  logic         in_last,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         err,
  output logic         ovf
);

  typedef enum logic [1:0] {
    S_OPND,  // expecting a digit
    S_NUM,   // digit seen, expecting an operator or the end
    S_ERR    // grammar violated; absorb characters until in_last
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [W-1:0]   prod_q, prod_d;
  logic           mul_pend_q, mul_pend_d;
  logic [W-1:0]   result_q, result_d;
  logic           result_valid_q, result_valid_d;
  logic           err_q, err_d;

  // Character decode. For '0'..'9' the low nibble equals in - 8'h30.
  logic           is_digit;
  logic           is_plus;
  logic           is_star;
  logic [3:0]     digit;

  // Full-precision arithmetic. The upper bits reveal wrap-around.
  logic [W+3:0]   prod_full;  // prod * digit
  logic [W+3:0]   term_full;  // value of the current product term
  logic [W-1:0]   term;
  logic [W:0]     add_full;   // sum + prod, on '+'
  logic [W:0]     final_full; // sum + term, on the last digit

  // Per-beat events for the optional overflow tracking.
  logic           hit;        // a wrap happened on this beat
  logic           done;       // in_last beat accepted
  logic           done_ok;    // in_last beat completed a well-formed expression

  always_comb begin
    is_digit   = (in >= 8'h30) && (in <= 8'h39);
    is_plus    = (in == 8'h2b);
    is_star    = (in == 8'h2a);
    digit      = in[3:0];

    prod_full  = {4'b0000, prod_q} * {{W{1'b0}}, digit};
    term_full  = mul_pend_q ? prod_full : {{W{1'b0}}, digit};
    term       = term_full[W-1:0];
    add_full   = {1'b0, sum_q} + {1'b0, prod_q};
    final_full = {1'b0, sum_q} + {1'b0, term};
  end

  // Next-state logic.
  // NOTE: every variable assigned below gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    prod_d         = prod_q;
    mul_pend_d     = mul_pend_q;
    result_d       = result_q;
    err_d          = err_q;
    result_valid_d = 1'b0;
    hit            = 1'b0;
    done           = 1'b0;
    done_ok        = 1'b0;

    if (in_valid) begin
      if (in_last) begin
        // Close the expression and rearm for the next one immediately.
        done           = 1'b1;
        result_valid_d = 1'b1;
        state_d        = S_OPND;
        sum_d          = '0;
        prod_d         = '0;
        mul_pend_d     = 1'b0;
        if (state_q == S_OPND && is_digit) begin
          done_ok  = 1'b1;
          result_d = final_full[W-1:0];
          err_d    = 1'b0;
          hit      = (mul_pend_q && (|term_full[W+3:W])) || final_full[W];
        end else begin
          result_d = '0;
          err_d    = 1'b1;
        end
      end else begin
        unique case (state_q)
          S_OPND: begin
            if (is_digit) begin
              prod_d     = term;
              mul_pend_d = 1'b0;
              state_d    = S_NUM;
              hit        = mul_pend_q && (|term_full[W+3:W]);
            end else begin
              state_d = S_ERR;
            end
          end
          S_NUM: begin
            if (is_plus) begin
              sum_d   = add_full[W-1:0];
              prod_d  = '0;
              state_d = S_OPND;
              hit     = add_full[W];
            end else if (is_star) begin
              mul_pend_d = 1'b1;
              state_d    = S_OPND;
            end else begin
              state_d = S_ERR;
            end
          end
          default: begin
            state_d = S_ERR;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q        <= S_OPND;
      sum_q          <= '0;
      prod_q         <= '0;
      mul_pend_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      prod_q         <= prod_d;
      mul_pend_q     <= mul_pend_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

`ifdef EXPR_EVAL_OVF_EN
  // Sticky wrap flag for the expression in progress; published on the result
  // pulse and cleared when the next expression starts.
  logic ovf_flag_q, ovf_flag_d;
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_flag_d = ovf_flag_q | hit;
    ovf_d      = ovf_q;
    if (done) begin
      ovf_flag_d = 1'b0;
      ovf_d      = done_ok & (ovf_flag_q | hit);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_flag_q <= ovf_flag_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Overflow tracking is compiled out; these events have no consumer.
  logic unused_ovf_events;
  assign unused_ovf_events = ^{hit, done, done_ok};
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_expr_eval.sv
// -----------------------------------------------------------------------------
// tb_expr_eval
//
// Directed bench for expr_eval with W=8. The driver pushes the hand-computed
// response of every expression into a scoreboard queue just before its final
// beat; a monitor pops and compares on every result_valid pulse, including
// the cycle on which the pulse appears. Pulses with nothing queued are errors.
// -----------------------------------------------------------------------------
module tb_expr_eval;

  localparam int W = 8;

`ifdef EXPR_EVAL_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         clr_n;
  logic         in_valid;
  logic [7:0]   in_ch;
  logic         in_last;
  logic [W-1:0] result;
  logic         result_valid;
  logic         err;
  logic         ovf;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  expr_eval #(.W(W)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .in_valid    (in_valid),
    .in          (in_ch),
    .in_last     (in_last),
    .result      (result),
    .result_valid(result_valid),
    .err         (err),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare away from the active edge.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("result", {{(32-W){1'b0}}, result}, {{(32-W){1'b0}}, e.res});
        check("err", {31'd0, err}, {31'd0, e.err});
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
  end

  // One accepted beat; returns just after the sampling edge.
  task automatic beat(input logic [7:0] c, input logic last);
    in_valid = 1'b1;
    in_ch    = c;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Drive an expression back-to-back; the last character carries in_last.
  task automatic send_expr(input string s, input int res, input logic e, input logic o);
    exp_t x;
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1) begin
        x.res = res[W-1:0];
        x.err = e;
        x.ovf = o & OVF_ON;
        x.cyc = cyc + 1;
        sb_q.push_back(x);
        beat(s[i], 1'b1);
      end else begin
        beat(s[i], 1'b0);
      end
    end
  endtask

  task automatic idle(input int n);
    // Garbage on the data lines must be ignored while in_valid is low.
    in_valid = 1'b0;
    in_ch    = "+";
    in_last  = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    in_last  = 1'b0;
  endtask

  initial begin
    clr_n    = 1'b0;
    in_valid = 1'b0;
    in_ch    = 8'h00;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", {{(32-W){1'b0}}, result}, 32'd0);
    check("reset_valid", {31'd0, result_valid}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    send_expr("2+3*4", 14, 1'b0, 1'b0);
    send_expr("7", 7, 1'b0, 1'b0);
    send_expr("9*9+1", 82, 1'b0, 1'b0);
    send_expr("3+*4", 0, 1'b1, 1'b0);
    send_expr("1+1", 2, 1'b0, 1'b0);
    send_expr("12", 0, 1'b1, 1'b0);
    send_expr("3+", 0, 1'b1, 1'b0);
    send_expr("+", 0, 1'b1, 1'b0);
    send_expr("0", 0, 1'b0, 1'b0);

    // Gap of three idle cycles inside an expression.
    beat("5", 1'b0);
    beat("*", 1'b0);
    idle(3);
    send_expr("6", 30, 1'b0, 1'b0);
    idle(2);

    // Reset mid-expression: no pulse, outputs cleared, clean restart.
    beat("8", 1'b0);
    beat("*", 1'b0);
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midreset_result", {{(32-W){1'b0}}, result}, 32'd0);
    check("midreset_err", {31'd0, err}, 32'd0);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
    send_expr("4", 4, 1'b0, 1'b0);

    // Wrap-around at W=8.
    send_expr("9*9*9", 217, 1'b0, 1'b1);
    send_expr("1+1", 2, 1'b0, 1'b0);
    send_expr("9*9*4", 68, 1'b0, 1'b1);
    send_expr("9*9*3+9*9", 68, 1'b0, 1'b1);  // only the sum wraps
    send_expr("9*9*9+", 0, 1'b1, 1'b0);      // error masks overflow
    send_expr("2*3+4", 10, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
